ramp_adc_ctrl: RTL

- Single-slope ADC conversion controller that sits directly upstream of the 8-bit counter and drives its en/set/setval inputs.
- On a start request it resets the analog ramp, zeroes the counter, and runs the counter until the comparator trips.
- It then captures the counter value as the conversion result and presents it on a valid/ready output handshake.
- A counter overflow before the comparator trips is treated as an out-of-range conversion.

---
 rtl/ramp_adc_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ramp_adc_ctrl.sv
// rtl/ramp_adc_ctrl.sv - single-slope ADC conversion controller driving an up-counter
// Optional: RAMP_ADC_LATENCY_COMP_EN subtracts the comparator synchroniser delay from the result.
module ramp_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp,
  input  logic [WIDTH-1:0] ctr_count,
  input  logic             ctr_overflow,
  output logic             ctr_en,
  output logic             ctr_set,
  output logic [WIDTH-1:0] ctr_setval,
  output logic             ramp_rst,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             saturated,
  output logic             result_valid,
  input  logic             result_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             settle_q, settle_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   sat_q, sat_d;
  logic                   cmp_s;
  logic [WIDTH-1:0]       raw_comp;

  assign cmp_s = sync_q[SYNC_STAGES-1];

`ifdef RAMP_ADC_LATENCY_COMP_EN
  localparam logic [WIDTH-1:0] LAT = WIDTH'(SYNC_STAGES);
  assign raw_comp = (ctr_count >= LAT) ? (ctr_count - LAT) : '0;
`else
  assign raw_comp = ctr_count;
`endif

  // Synchroniser is held clear outside CONVERT so a comparator that is already
  // high still needs SYNC_STAGES counted cycles to register as a trip.
  always_comb begin
    sync_d = '0;
    if (state_q == CONVERT) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], cmp};
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    result_d = result_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE;
          settle_d = 4'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = CONVERT;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CONVERT: begin
        if (ctr_overflow) begin
          state_d  = DONE;
          result_d = '1;
          sat_d    = 1'b1;
        end else if (cmp_s) begin
          state_d  = DONE;
          result_d = raw_comp;
          sat_d    = 1'b0;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      sync_q   <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      sync_q   <= sync_d;
      result_q <= result_d;
      sat_q    <= sat_d;
    end
  end

  assign ctr_en       = (state_q == CONVERT);
  assign ctr_set      = (state_q == SETTLE);
  assign ctr_setval   = '0;
  assign ramp_rst     = (state_q != CONVERT);
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;
  assign saturated    = sat_q;

endmodule
